// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding, default
// sizing constants and a helper for sizing requester index fields.
// Optional feature macro: ADDER_ARBITER_OVF_EN (adds the rsp_ovf flag).
package adder_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_NREQ       = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the requesters and the adder arbiter.
// The master side issues requests and operands; the slave side (the
// arbiter) returns grants and results.
// Optional feature macro: ADDER_ARBITER_OVF_EN (adds rsp_ovf).
interface adder_arbiter_if
    import adder_arbiter_pkg::*;
#(
    parameter int NREQ       = DEFAULT_NREQ,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    localparam int IDW = idWidth(NREQ);

    logic [NREQ-1:0]                 req;
    logic [NREQ-1:0][DATA_WIDTH-1:0] op_a;
    logic [NREQ-1:0][DATA_WIDTH-1:0] op_b;
    logic [NREQ-1:0]                 gnt;
    logic                            rsp_valid;
    logic [IDW-1:0]                  rsp_id;
    logic [DATA_WIDTH-1:0]           rsp_data;
    logic                            busy;
`ifdef ADDER_ARBITER_OVF_EN
    logic                            rsp_ovf;
`endif

    modport master (
        output req, op_a, op_b,
`ifdef ADDER_ARBITER_OVF_EN
        input  rsp_ovf,
`endif
        input  gnt, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req, op_a, op_b,
`ifdef ADDER_ARBITER_OVF_EN
        output rsp_ovf,
`endif
        output gnt, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/adder_arbiter_adder.sv
// The shared unsigned adder. With CARRY set, the sum is one bit wider so
// the carry-out is visible; otherwise it wraps at WIDTH bits.
module adder_arbiter_adder #(
    parameter int WIDTH = 32,
    parameter bit CARRY = 1'b0,
    localparam int OW   = WIDTH + (CARRY ? 1 : 0)
) (
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic [OW-1:0]    outputSum
);

    assign outputSum = OW'(inputA) + OW'(inputB);

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing a single adder among NREQ requesters.
// A request sampled in IDLE is granted for one ADD cycle while its operands
// feed the adder; the registered sum is presented for one DONE cycle.
// Optional feature macro: ADDER_ARBITER_OVF_EN (carry-out flag rsp_ovf).
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NREQ       = DEFAULT_NREQ,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    adder_arbiter_if.slave bus
);

    localparam int IDW = idWidth(NREQ);
`ifdef ADDER_ARBITER_OVF_EN
    localparam int SUMW = DATA_WIDTH + 1;
`else
    localparam int SUMW = DATA_WIDTH;
`endif

    state_t                r_state;
    state_t                w_nextState;
    logic                  w_capture;
    logic                  w_finish;
    logic                  w_retire;

    logic [IDW-1:0]        r_rrPtr;
    logic [IDW-1:0]        r_owner;
    logic [IDW-1:0]        w_winner;
    logic [IDW-1:0]        w_cand;
    logic                  w_anyReq;
    int                    w_sumIdx;

    logic [DATA_WIDTH-1:0] r_opA;
    logic [DATA_WIDTH-1:0] r_opB;
    logic [SUMW-1:0]       w_sum;

    logic [NREQ-1:0]       r_gnt;
    logic                  r_rspValid;
    logic [IDW-1:0]        r_rspId;
    logic [DATA_WIDTH-1:0] r_rspData;
`ifdef ADDER_ARBITER_OVF_EN
    logic                  r_rspOvf;
`endif

    // Round-robin pick: scan from r_rrPtr upward with wrap, first active request wins.
    always_comb begin
        w_anyReq = 1'b0;
        w_winner = '0;
        w_sumIdx = 0;
        w_cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sumIdx = int'(r_rrPtr) + i;
            if (w_sumIdx >= NREQ) begin
                w_sumIdx = w_sumIdx - NREQ;
            end
            w_cand = IDW'(w_sumIdx);
            if (!w_anyReq && bus.req[w_cand]) begin
                w_anyReq = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Next-state logic plus the one-cycle strobes marking each transition.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_finish    = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ADD;
                    w_capture   = 1'b1;
                end
            end
            ADD: begin
                w_nextState = DONE;
                w_finish    = 1'b1;
            end
            DONE: begin
                w_nextState = IDLE;
                w_retire    = 1'b1;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register; reset wins over any pending transition and aborts a transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operand capture, grant/result pulses, held result fields and pointer advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_opA      <= '0;
            r_opB      <= '0;
            r_owner    <= '0;
            r_rrPtr    <= '0;
            r_gnt      <= '0;
            r_rspValid <= 1'b0;
            r_rspId    <= '0;
            r_rspData  <= '0;
`ifdef ADDER_ARBITER_OVF_EN
            r_rspOvf   <= 1'b0;
`endif
        end else begin
            r_gnt      <= '0;
            r_rspValid <= 1'b0;
            if (w_capture) begin
                r_opA   <= bus.op_a[w_winner];
                r_opB   <= bus.op_b[w_winner];
                r_owner <= w_winner;
                r_gnt   <= NREQ'(1) << w_winner;
            end
            if (w_finish) begin
                r_rspData  <= w_sum[DATA_WIDTH-1:0];
                r_rspId    <= r_owner;
                r_rspValid <= 1'b1;
`ifdef ADDER_ARBITER_OVF_EN
                r_rspOvf   <= w_sum[DATA_WIDTH];
`endif
            end
            if (w_retire) begin
                r_rrPtr <= (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + IDW'(1);
            end
        end
    end

`ifdef ADDER_ARBITER_OVF_EN
    adder_arbiter_adder #(.WIDTH(DATA_WIDTH), .CARRY(1'b1)) u_adder (
`else
    adder_arbiter_adder #(.WIDTH(DATA_WIDTH), .CARRY(1'b0)) u_adder (
`endif
        .inputA    (r_opA),
        .inputB    (r_opB),
        .outputSum (w_sum)
    );

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_id    = r_rspId;
    assign bus.rsp_data  = r_rspData;
    assign bus.busy      = (r_state != IDLE);
`ifdef ADDER_ARBITER_OVF_EN
    assign bus.rsp_ovf   = r_rspOvf;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter (NREQ=4, DATA_WIDTH=32).
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Optional feature macro: ADDER_ARBITER_OVF_EN (also checks rsp_ovf).
module tb_adder_arbiter;

    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    adder_arbiter_if #(.NREQ(4), .DATA_WIDTH(32)) bus ();

    adder_arbiter #(.NREQ(4), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One full IDLE->ADD->DONE->IDLE transaction whose request is already
    // visible to the next rising edge.
    task automatic applyStimulus(input string tag, input int expId,
                                 input logic [31:0] expSum, input logic expOvf,
                                 input bit keepReq);
        @(negedge clk);
        checkOutput({tag, " gnt"}, 64'(bus.gnt), 64'(1) << expId);
        checkOutput({tag, " busyAdd"}, 64'(bus.busy), 64'(1));
        checkOutput({tag, " validAdd"}, 64'(bus.rsp_valid), 64'(0));
        if (!keepReq) begin
            bus.req[expId] = 1'b0;
        end
        @(negedge clk);
        checkOutput({tag, " valid"}, 64'(bus.rsp_valid), 64'(1));
        checkOutput({tag, " id"}, 64'(bus.rsp_id), 64'(expId));
        checkOutput({tag, " data"}, 64'(bus.rsp_data), 64'(expSum));
        checkOutput({tag, " gntDone"}, 64'(bus.gnt), 64'(0));
`ifdef ADDER_ARBITER_OVF_EN
        checkOutput({tag, " ovf"}, 64'(bus.rsp_ovf), 64'(expOvf));
`else
        if (expOvf !== 1'b0 && expOvf !== 1'b1) begin
            $display("[TB] note: %s overflow expectation unused", tag);
        end
`endif
        @(negedge clk);
        checkOutput({tag, " validIdle"}, 64'(bus.rsp_valid), 64'(0));
        checkOutput({tag, " busyIdle"}, 64'(bus.busy), 64'(0));
        checkOutput({tag, " dataHeld"}, 64'(bus.rsp_data), 64'(expSum));
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b0;
        bus.req     = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.op_a[i] = 32'h11;
            bus.op_b[i] = 32'h22;
        end

        // Reset held three cycles with every request active.
        repeat (3) @(negedge clk);
        checkOutput("rst gnt", 64'(bus.gnt), 64'(0));
        checkOutput("rst valid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("rst busy", 64'(bus.busy), 64'(0));
        checkOutput("rst data", 64'(bus.rsp_data), 64'(0));
        checkOutput("rst id", 64'(bus.rsp_id), 64'(0));
        reset   = 1'b1;
        bus.req = 4'b0000;
        @(negedge clk);
        checkOutput("idle busy", 64'(bus.busy), 64'(0));

        // Single request from requester 2: 5 + 7.
        bus.op_a[2] = 32'd5;
        bus.op_b[2] = 32'd7;
        bus.req     = 4'b0100;
        applyStimulus("single", 2, 32'd12, 1'b0, 1'b0);

        // Wrap-around; pointer is 3 so requester 1 is found after wrapping.
        bus.op_a[1] = 32'hFFFF_FFFF;
        bus.op_b[1] = 32'd2;
        bus.req     = 4'b0010;
        applyStimulus("wrap", 1, 32'd1, 1'b1, 1'b0);
        bus.op_a[1] = 32'd1;
        bus.op_b[1] = 32'd2;
        bus.req     = 4'b0010;
        applyStimulus("nowrap", 1, 32'd3, 1'b0, 1'b0);

        // Reset again to bring the round-robin pointer back to 0.
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst2 data", 64'(bus.rsp_data), 64'(0));
        reset = 1'b1;

        // Fairness with all four requesting continuously.
        for (int i = 0; i < 4; i++) begin
            bus.op_a[i] = 32'(i * 16);
            bus.op_b[i] = 32'(i + 3);
        end
        bus.req = 4'b1111;
        applyStimulus("fair0", 0, 32'd3, 1'b0, 1'b1);
        applyStimulus("fair1", 1, 32'd20, 1'b0, 1'b1);
        applyStimulus("fair2", 2, 32'd37, 1'b0, 1'b1);
        applyStimulus("fair3", 3, 32'd54, 1'b0, 1'b1);
        applyStimulus("fair4", 0, 32'd3, 1'b0, 1'b1);
        bus.req = 4'b0000;

        // Reset during ADD of requester 1 aborts the transaction.
        bus.op_a[1] = 32'd9;
        bus.op_b[1] = 32'd9;
        bus.req     = 4'b0010;
        @(negedge clk);
        checkOutput("abort gnt", 64'(bus.gnt), 64'(4'b0010));
        reset   = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);
        checkOutput("abort valid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("abort busy", 64'(bus.busy), 64'(0));
        checkOutput("abort data", 64'(bus.rsp_data), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort valid2", 64'(bus.rsp_valid), 64'(0));
        bus.op_a[3] = 32'd40;
        bus.op_b[3] = 32'd2;
        bus.req     = 4'b1000;
        applyStimulus("post", 3, 32'd42, 1'b0, 1'b0);

        // Late request from requester 0 raised during ADD of requester 1.
        bus.op_a[0] = 32'd7;
        bus.op_b[0] = 32'd8;
        bus.op_a[1] = 32'd100;
        bus.op_b[1] = 32'd23;
        bus.req     = 4'b0010;
        @(negedge clk);
        checkOutput("late gnt1", 64'(bus.gnt), 64'(4'b0010));
        bus.req = 4'b0001;
        @(negedge clk);
        checkOutput("late valid", 64'(bus.rsp_valid), 64'(1));
        checkOutput("late id", 64'(bus.rsp_id), 64'(1));
        checkOutput("late data", 64'(bus.rsp_data), 64'(123));
        checkOutput("late gntDone", 64'(bus.gnt), 64'(0));
        @(negedge clk);
        checkOutput("late idleBusy", 64'(bus.busy), 64'(0));
        checkOutput("late idleGnt", 64'(bus.gnt), 64'(0));
        applyStimulus("late0", 0, 32'd15, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 Parameter DATA_WIDTH, default 32, operand/result width in bits.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low.
REQ-005 req  input  NREQ  per-requester add request, level-held until granted.
REQ-006 op_a  input  NREQ x DATA_WIDTH  per-requester operand A, stable while req high.
REQ-007 op_b  input  NREQ x DATA_WIDTH  per-requester operand B, stable while req high.
REQ-008 gnt  output  NREQ  one-hot grant pulse, one cycle, marks operand capture.
REQ-009 rsp_valid  output  1  result valid pulse, one cycle.
REQ-010 rsp_id  output  clog2(NREQ)  index of requester owning the current result.
REQ-011 rsp_data  output  DATA_WIDTH  sum op_a+op_b, modulo 2^DATA_WIDTH.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states IDLE, ADD, DONE; IDLE->ADD when any req bit is high at the edge; ADD->DONE unconditionally; DONE->IDLE unconditionally.
REQ-014 req is sampled only in IDLE; req in ADD/DONE is ignored and holds no priority credit.
REQ-015 Winner selection is round-robin: search starts at index rr_ptr, wraps from NREQ-1 to 0, first high req wins.
REQ-016 On IDLE->ADD: op_a/op_b of winner captured into operand registers, winner index captured, gnt[winner] registered high for the ADD cycle only.
REQ-017 In ADD the captured operands drive the shared adder; at ADD->DONE the adder output is registered into rsp_data, rsp_id set to owner, rsp_valid high for the DONE cycle only.
REQ-018 At DONE->IDLE rr_ptr updates to (owner+1) mod NREQ; rr_ptr unchanged otherwise.
REQ-019 Latency: req sampled at edge k -> gnt high in cycle k+1 -> rsp_valid high in cycle k+2; throughput one add per 3 cycles.
REQ-020 Requester deasserts req at the edge after observing gnt; a req still high on return to IDLE is treated as a new request.
REQ-021 rsp_data and rsp_id hold their last values outside DONE; only rsp_valid qualifies them.
REQ-022 All-requesters-active: grants rotate 0,1,...,NREQ-1,0 with no requester served twice before each other active one is served once.
REQ-023 Arithmetic is unsigned, carry-out discarded (wrap-around), except as REQ-028.

Reset
REQ-024 reset low at an edge forces state IDLE, gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, rr_ptr=0, operand registers 0.
REQ-025 Reset mid-operation (ADD or DONE) aborts the transaction: no rsp_valid is produced for it.
REQ-026 reset has priority over every other event in the same cycle.

Configuration
REQ-027 Macro ADDER_ARBITER_OVF_EN selects an overflow-flag feature.
REQ-028 Defined: extra output rsp_ovf (1 bit) registered with rsp_data, high when the unsigned sum carries out of DATA_WIDTH, reset 0, held like rsp_data.
REQ-029 Undefined: rsp_ovf port and its logic are absent; all other behaviour identical.

Structure
REQ-030 Shared package holds the FSM state enum (IDLE, ADD, DONE) and default NREQ/DATA_WIDTH constants.
REQ-031 Exactly one instance of the existing adder sub-module (inputs inputA/inputB, output outputSum) performs the addition; no other adder in the block.

Verification
REQ-032 Reset: hold reset low 3 cycles with req=all ones -> gnt=0, rsp_valid=0, busy=0, rsp_data=0.
REQ-033 Single request: req[2]=1, op_a=5, op_b=7 at edge k -> gnt=4'b0100 in k+1, rsp_valid=1, rsp_id=2, rsp_data=12 in k+2.
REQ-034 Wrap: op_a=32'hFFFF_FFFF, op_b=2 -> rsp_data=1; with ADDER_ARBITER_OVF_EN rsp_ovf=1, with op_a=1, op_b=2 rsp_ovf=0.
REQ-035 Fairness: req=4'b1111 held continuously (re-raised after each gnt) -> grant order 0,1,2,3,0, rsp_id matching each, one rsp_valid every 3 cycles.
REQ-036 Reset mid-op: grant requester 1, assert reset low during ADD -> no rsp_valid follows; next request from requester 3 after reset granted with rr_ptr=0 search.
REQ-037 Late request: req[0] raised during ADD of requester 1 -> ignored until IDLE, then granted; rsp_data of requester 1 unaffected.
